// File: rtl/cassette_tone_gen.sv
// cassette_tone_gen: 8N1 byte framer producing 1200/2400 Hz cassette square-wave tone with leader and idle high tone.
module cassette_tone_gen #(
    parameter int HALF_SHORT  = 256,
    parameter int LEADER_BITS = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       motor,
    input  logic [7:0] tdata,
    input  logic       tvalid,
    output logic       tready,
    output logic       cas_out,
    output logic       carrier,
    output logic       busy
);
    localparam int PW = $clog2(4*HALF_SHORT);
    localparam int LW = $clog2(LEADER_BITS+1);

    typedef enum logic [1:0] {IDLE, LEADER, HOLD, FRAME} state_t;

    state_t        state, state_n;
    logic [PW-1:0] phase, phase_n;
    logic [LW-1:0] lcnt, lcnt_n;
    logic [3:0]    bidx, bidx_n;
    logic [9:0]    sh, sh_n;
    logic [7:0]    buf_q, buf_n;
    logic          buf_full, buf_full_n;
    logic          bnd, go, bit_n;

    // Square wave is low in the first half of each half-period pair, so every bit starts low.
    function automatic logic wave(input logic [PW-1:0] p, input logic b);
        int q;
        q = int'(p);
        return b ? ((q >= HALF_SHORT && q < 2*HALF_SHORT) || q >= 3*HALF_SHORT) : (q >= 2*HALF_SHORT);
    endfunction

    assign bnd = phase == PW'(4*HALF_SHORT-1);

    always_comb begin
        state_n    = state;
        phase_n    = phase;
        lcnt_n     = lcnt;
        bidx_n     = bidx;
        sh_n       = sh;
        buf_n      = buf_q;
        buf_full_n = buf_full;
        go         = 1'b0;
        if (!motor) begin
            state_n    = IDLE;
            phase_n    = '0;
            buf_full_n = 1'b0;
        end else if (state == IDLE) begin
            state_n = LEADER;
            phase_n = '0;
            lcnt_n  = '0;
        end else begin
            phase_n = bnd ? '0 : phase + 1'b1;
            if (tvalid && tready) begin
                buf_n      = tdata;
                buf_full_n = 1'b1;
            end
            if (bnd) begin
                case (state)
                    LEADER: begin
                        lcnt_n = lcnt + 1'b1;
                        go     = lcnt == LW'(LEADER_BITS-1);
                    end
                    HOLD: go = 1'b1;
                    default: begin
                        go     = bidx == 4'd9;
                        bidx_n = bidx + 4'd1;
                        sh_n   = {1'b1, sh[9:1]};
                    end
                endcase
            end
            if (go) begin
                state_n = buf_full ? FRAME : HOLD;
                if (buf_full) begin
                    sh_n       = {1'b1, buf_q, 1'b0};
                    bidx_n     = 4'd0;
                    buf_full_n = 1'b0;
                end
            end
        end
        bit_n = state_n == FRAME ? sh_n[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= '0;
            lcnt     <= '0;
            bidx     <= '0;
            sh       <= '1;
            buf_q    <= '0;
            buf_full <= 1'b0;
            tready   <= 1'b0;
            cas_out  <= 1'b0;
            carrier  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            lcnt     <= lcnt_n;
            bidx     <= bidx_n;
            sh       <= sh_n;
            buf_q    <= buf_n;
            buf_full <= buf_full_n;
            tready   <= motor && !buf_full_n;
            cas_out  <= state_n != IDLE && wave(phase_n, bit_n);
            carrier  <= state_n != IDLE;
            busy     <= state_n == FRAME || buf_full_n;
        end
    end
endmodule
